// File: rtl/aximm_seq_pkg.sv
// Shared CSR map, state/fail-code types and verdict helper for the
// AXI-MM AIB loopback self-test sequencer.
package aximm_seq_pkg;

  localparam logic [31:0] ADDR_DLY_X      = 32'h5000_2000;
  localparam logic [31:0] ADDR_DLY_Y      = 32'h5000_2004;
  localparam logic [31:0] ADDR_DLY_Z      = 32'h5000_2008;
  localparam logic [31:0] ADDR_WR_CFG     = 32'h5000_1000;
  localparam logic [31:0] ADDR_WR_RD_ADDR = 32'h5000_1004;
  localparam logic [31:0] ADDR_BUS_STS    = 32'h5000_1008;
  localparam logic [31:0] ADDR_LINKUP     = 32'h5000_100C;
  localparam logic [31:0] ADDR_RD_CFG     = 32'h5000_1010;

  localparam int STS_WR_DONE = 4;
  localparam int STS_RD_DONE = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_DLY,
    S_POLL_LINK,
    S_START_WR,
    S_POLL_WR,
    S_START_RD,
    S_POLL_RD,
    S_READ_STS,
    S_DONE
  } seq_state_e;

  typedef enum logic {
    PH_XACT,
    PH_GAP
  } seq_phase_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_REQ,
    X_RDATA
  } xact_state_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_LINK_TO  = 3'd1,
    FC_WR_TO    = 3'd2,
    FC_RD_TO    = 3'd3,
    FC_MISMATCH = 3'd4,
    FC_ALIGN    = 3'd5
  } fail_code_e;

  // Alignment bits are judged before the data-compare bit.
  function automatic fail_code_e status_verdict(input logic [3:0] sts);
    if (!sts[3] || !sts[2]) return FC_ALIGN;
    else if (sts == 4'b1110) return FC_MISMATCH;
    else if (sts == 4'b1111) return FC_NONE;
    else return FC_MISMATCH;
  endfunction

endpackage

// File: rtl/aximm_test_sequencer_xact.sv
// Single-outstanding AVMM transaction engine: launches one read or write,
// owns the waitrequest/readdatavalid handshake and pulses done once finished.
module aximm_avmm_xact
  import aximm_seq_pkg::*;
(
  input  logic        avmm_clk,
  input  logic        avmm_rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid
);

  xact_state_e state_q, state_d;
  logic        we_q;

  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) state_q <= X_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      X_IDLE:  if (req) state_d = X_REQ;
      X_REQ:   if (!waitrequest) state_d = we_q ? X_IDLE : X_RDATA;
      X_RDATA: if (readdatavalid) state_d = X_IDLE;
      default: state_d = X_IDLE;
    endcase
  end

  // readdatavalid outside X_RDATA is stray and never captured.
  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      address   <= '0;
      writedata <= '0;
      we_q      <= 1'b0;
      rdata     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == X_IDLE && req) begin
        address   <= addr;
        writedata <= wdata;
        we_q      <= we;
      end
      if (state_q == X_REQ && !waitrequest && we_q) done <= 1'b1;
      if (state_q == X_RDATA && readdatavalid) begin
        rdata <= readdata;
        done  <= 1'b1;
      end
    end
  end

  assign write = (state_q == X_REQ) && we_q;
  assign read  = (state_q == X_REQ) && !we_q;

endmodule

// File: rtl/aximm_test_sequencer.sv
// AVMM master that walks the AXI-MM AIB loopback self-test through the CSR
// space and reports a pass/fail verdict.
//
// state       | meaning
// S_IDLE      | waiting for start
// S_CFG_DLY   | writing delay X/Y/Z
// S_POLL_LINK | polling link-up nibble
// S_START_WR  | programming AXI address and write burst
// S_POLL_WR   | polling write-done bit
// S_START_RD  | programming AXI address and read burst
// S_POLL_RD   | polling read-done bit
// S_READ_STS  | final bus-status read
// S_DONE      | verdict held, restartable
module aximm_test_sequencer
  import aximm_seq_pkg::*;
#(
  parameter logic [31:0] DLY_X      = 32'h0000_000C,
  parameter logic [31:0] DLY_Y      = 32'h0000_0020,
  parameter logic [31:0] DLY_Z      = 32'h0000_1770,
  parameter logic [31:0] XFER_ADDR  = 32'h1000_0000,
  parameter logic [31:0] XFER_CFG   = 32'h0004_1804,
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic        avmm_clk,
  input  logic        avmm_rst_n,
  input  logic        i_start,
  output logic [31:0] o_address,
  output logic        o_write,
  output logic        o_read,
  output logic [31:0] o_writedata,
  input  logic        i_waitrequest,
  input  logic [31:0] i_readdata,
  input  logic        i_readdatavalid,
  output logic        o_busy,
  output logic        o_test_done,
  output logic        o_test_pass,
  output logic [2:0]  o_fail_code,
  output logic [31:0] o_last_status
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);

  seq_state_e     state_q, state_d;
  seq_phase_e     phase_q, phase_d;
  logic [1:0]     step_q, step_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic           pass_q, pass_d;
  fail_code_e     code_q, code_d;
  logic [31:0]    last_sts_q;

  logic           start_ok, poll_hit, launch;
  logic           issue_we;
  logic [31:0]    issue_addr, issue_wdata;
  logic           xact_done;
  logic [31:0]    xact_rdata;

  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      state_q <= S_IDLE;
      phase_q <= PH_XACT;
      step_q  <= '0;
      poll_q  <= '0;
      gap_q   <= '0;
      pass_q  <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) last_sts_q <= '0;
    else if (xact_done && (state_q == S_POLL_WR || state_q == S_POLL_RD ||
                           state_q == S_READ_STS))
      last_sts_q <= xact_rdata;
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    step_d   = step_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
    pass_d   = pass_q;
    code_d   = code_q;
    launch   = 1'b0;
    start_ok = i_start && (state_q == S_IDLE || state_q == S_DONE);
    case (state_q)
      S_POLL_LINK: poll_hit = (xact_rdata[3:0] == 4'hF);
      S_POLL_WR:   poll_hit = xact_rdata[STS_WR_DONE];
      S_POLL_RD:   poll_hit = xact_rdata[STS_RD_DONE];
      default:     poll_hit = 1'b0;
    endcase

    if (start_ok) begin
      state_d = S_CFG_DLY;
      phase_d = PH_XACT;
      step_d  = '0;
      pass_d  = 1'b0;
      code_d  = FC_NONE;
      launch  = 1'b1;
    end else if (phase_q == PH_GAP) begin
      if (gap_q == GCW'(1)) begin
        phase_d = PH_XACT;
        launch  = 1'b1;
      end else begin
        gap_d = gap_q - 1'b1;
      end
    end else if (xact_done) begin
      case (state_q)
        S_CFG_DLY: begin
          launch = 1'b1;
          if (step_q == 2'd2) begin
            state_d = S_POLL_LINK;
            step_d  = '0;
            poll_d  = '0;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
        S_START_WR, S_START_RD: begin
          launch = 1'b1;
          if (step_q == 2'd1) begin
            if (state_q == S_START_WR) state_d = S_POLL_WR;
            else                       state_d = S_POLL_RD;
            step_d = '0;
            poll_d = '0;
          end else begin
            step_d = 2'd1;
          end
        end
        S_POLL_LINK, S_POLL_WR, S_POLL_RD: begin
          if (poll_hit) begin
            launch = 1'b1;
            step_d = '0;
            if (state_q == S_POLL_LINK)    state_d = S_START_WR;
            else if (state_q == S_POLL_WR) state_d = S_START_RD;
            else                           state_d = S_READ_STS;
          end else if (poll_q == PCW'(POLL_LIMIT - 1)) begin
            state_d = S_DONE;
            pass_d  = 1'b0;
            if (state_q == S_POLL_LINK)    code_d = FC_LINK_TO;
            else if (state_q == S_POLL_WR) code_d = FC_WR_TO;
            else                           code_d = FC_RD_TO;
          end else begin
            poll_d  = poll_q + 1'b1;
            phase_d = PH_GAP;
            gap_d   = GCW'(POLL_GAP);
          end
        end
        S_READ_STS: begin
          state_d = S_DONE;
          code_d  = status_verdict(xact_rdata[3:0]);
          pass_d  = (code_d == FC_NONE);
        end
        default: ;
      endcase
    end
  end

  // First (or next) transaction of the state being entered or continued.
  always_comb begin
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
    if (launch) begin
      case (state_d)
        S_CFG_DLY: begin
          issue_we = 1'b1;
          case (step_d)
            2'd0:    begin issue_addr = ADDR_DLY_X; issue_wdata = DLY_X; end
            2'd1:    begin issue_addr = ADDR_DLY_Y; issue_wdata = DLY_Y; end
            default: begin issue_addr = ADDR_DLY_Z; issue_wdata = DLY_Z; end
          endcase
        end
        S_START_WR, S_START_RD: begin
          issue_we = 1'b1;
          if (step_d == 2'd0) begin
            issue_addr  = ADDR_WR_RD_ADDR;
            issue_wdata = XFER_ADDR;
          end else begin
            issue_addr  = (state_d == S_START_WR) ? ADDR_WR_CFG : ADDR_RD_CFG;
            issue_wdata = XFER_CFG;
          end
        end
        S_POLL_LINK: issue_addr = ADDR_LINKUP;
        S_POLL_WR, S_POLL_RD, S_READ_STS: issue_addr = ADDR_BUS_STS;
        default: ;
      endcase
    end
  end

  aximm_avmm_xact u_xact (
    .avmm_clk      (avmm_clk),
    .avmm_rst_n    (avmm_rst_n),
    .req           (launch),
    .we            (issue_we),
    .addr          (issue_addr),
    .wdata         (issue_wdata),
    .done          (xact_done),
    .rdata         (xact_rdata),
    .address       (o_address),
    .write         (o_write),
    .read          (o_read),
    .writedata     (o_writedata),
    .waitrequest   (i_waitrequest),
    .readdata      (i_readdata),
    .readdatavalid (i_readdatavalid)
  );

  assign o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_test_done   = (state_q == S_DONE);
  assign o_test_pass   = pass_q;
  assign o_fail_code   = code_q;
  assign o_last_status = last_sts_q;

endmodule

// File: tb/tb_aximm_test_sequencer.sv
// Randomised scoreboard bench for aximm_test_sequencer: a CSR slave model
// answers polls, expected writes and verdicts are queued and checked by monitors.
`timescale 1ns/1ps
module tb_aximm_test_sequencer;

  localparam logic [31:0] A_DX   = 32'h5000_2000;
  localparam logic [31:0] A_DY   = 32'h5000_2004;
  localparam logic [31:0] A_DZ   = 32'h5000_2008;
  localparam logic [31:0] A_WCFG = 32'h5000_1000;
  localparam logic [31:0] A_XADR = 32'h5000_1004;
  localparam logic [31:0] A_STS  = 32'h5000_1008;
  localparam logic [31:0] A_LINK = 32'h5000_100C;
  localparam logic [31:0] A_RCFG = 32'h5000_1010;
  localparam int GAP  = 16;
  localparam int LIM1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] addr0, wdat0, rdat0, last0, addr1, wdat1, rdat1, last1;
  logic        wr0, rd0, wait0, rdv0, busy0, done0, pass0;
  logic        wr1, rd1, wait1, rdv1, busy1, done1, pass1;
  logic [2:0]  code0, code1;

  aximm_test_sequencer dut0 (
    .avmm_clk(clk), .avmm_rst_n(rst_n), .i_start(start0),
    .o_address(addr0), .o_write(wr0), .o_read(rd0), .o_writedata(wdat0),
    .i_waitrequest(wait0), .i_readdata(rdat0), .i_readdatavalid(rdv0),
    .o_busy(busy0), .o_test_done(done0), .o_test_pass(pass0),
    .o_fail_code(code0), .o_last_status(last0));

  aximm_test_sequencer #(.POLL_GAP(GAP), .POLL_LIMIT(LIM1)) dut1 (
    .avmm_clk(clk), .avmm_rst_n(rst_n), .i_start(start1),
    .o_address(addr1), .o_write(wr1), .o_read(rd1), .o_writedata(wdat1),
    .i_waitrequest(wait1), .i_readdata(rdat1), .i_readdatavalid(rdv1),
    .o_busy(busy1), .o_test_done(done1), .o_test_pass(pass1),
    .o_fail_code(code1), .o_last_status(last1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // {pass, code} from the final status nibble.
  function automatic logic [3:0] exp_verdict(input logic [3:0] s);
    if (s == 4'hF) return {1'b1, 3'd0};
    if (s[3] && s[2]) return {1'b0, 3'd4};
    return {1'b0, 3'd5};
  endfunction

  // ---------------- slave model for dut0 ----------------
  int          wait_cycles, link_at, wr_at, rd_at;
  logic [31:0] final_sts;
  int          n_link, n_wrp, n_rdp, n_final;
  bit          rd_phase, inreq, stray;
  int          hold, rcnt;
  logic [31:0] cap_a, cap_d, rsp;
  bit          cap_w;
  logic [63:0] exp_wr_q[$];
  logic [35:0] exp_v_q[$];
  logic [35:0] exp_v1_q[$];

  initial begin
    wait0 = 1'b0; rdv0 = 1'b0; rdat0 = '0;
    wait1 = 1'b0; rdv1 = 1'b0; rdat1 = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      wait0 = 1'b0; rdv0 = 1'b0; rcnt = 0; inreq = 1'b0;
    end else begin
      rdv0 = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin rdv0 = 1'b1; rdat0 = rsp; end
      end
      if (stray) begin rdv0 = 1'b1; rdat0 = 32'hFFFF_FFFF; stray = 1'b0; end
      if (rd0 || wr0) begin
        if (!inreq) begin
          inreq = 1'b1; hold = 0; cap_a = addr0; cap_d = wdat0; cap_w = wr0;
        end else begin
          check("stall_hold", {addr0, wdat0}, {cap_a, cap_d});
          check("stall_strobe", {30'd0, wr0, rd0}, {30'd0, cap_w, !cap_w});
        end
        if (hold < wait_cycles) begin
          wait0 = 1'b1; hold++;
        end else begin
          wait0 = 1'b0; inreq = 1'b0;
          if (cap_w) begin
            if (exp_wr_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL wr_extra: got %0h=%0h, expected no write", cap_a, cap_d);
            end else begin
              check("wr_seq", {cap_a, cap_d}, exp_wr_q.pop_front());
            end
            if (cap_a == A_RCFG) rd_phase = 1'b1;
          end else begin
            rcnt = 2;
            if (cap_a == A_LINK) begin
              n_link++;
              rsp = (n_link >= link_at) ? 32'hF : ($urandom & 32'hFFFF_FFF7);
            end else if (cap_a == A_STS && !rd_phase) begin
              n_wrp++;
              rsp = (n_wrp >= wr_at) ? ($urandom | 32'h10) : ($urandom & ~32'h10);
            end else if (cap_a == A_STS && n_rdp < rd_at) begin
              n_rdp++;
              rsp = (n_rdp >= rd_at) ? ($urandom | 32'h20) : ($urandom & ~32'h20);
            end else if (cap_a == A_STS) begin
              n_final++;
              rsp = final_sts;
            end else begin
              n_chk++; n_fail++;
              $display("FAIL rd_addr: got %0h, expected a CSR poll address", cap_a);
              rsp = '0;
            end
          end
        end
      end else begin
        wait0 = 1'b0;
      end
    end
  end

  // ---------------- slave model for dut1 (link never comes up) ----------------
  int cyc = 0;
  int n_link1 = 0, n_wr1 = 0, n_wrcfg1 = 0, n_bad1 = 0, rc1 = 0;
  int last_t1 = -1, min_sp1 = 1 << 30;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    rdv1 = 1'b0;
    if (!rst_n) rc1 = 0;
    else begin
      if (rc1 > 0) begin
        rc1--;
        if (rc1 == 0) begin rdv1 = 1'b1; rdat1 = $urandom & 32'hFFFF_FFF7; end
      end
      if (rd1) begin
        if (addr1 == A_LINK) n_link1++; else n_bad1++;
        if (last_t1 >= 0 && cyc - last_t1 < min_sp1) min_sp1 = cyc - last_t1;
        last_t1 = cyc;
        rc1 = 2;
      end
      if (wr1) begin
        n_wr1++;
        if (addr1 == A_WCFG) n_wrcfg1++;
      end
    end
  end

  // ---------------- verdict monitors ----------------
  bit done0_prev = 1'b0, done1_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && done0 && !done0_prev) begin
      if (exp_v_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done0_extra: got done, expected none");
      end else begin
        check("verdict0", {pass0, code0, last0}, exp_v_q.pop_front());
        check("busy0_in_done", {63'd0, busy0}, 64'd0);
      end
    end
    if (rst_n && done1 && !done1_prev) begin
      if (exp_v1_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done1_extra: got done, expected none");
      end else begin
        check("verdict1", {pass1, code1, last1}, exp_v1_q.pop_front());
      end
    end
    done0_prev = done0;
    done1_prev = done1;
  end

  // ---------------- stimulus ----------------
  task automatic push_writes();
    exp_wr_q.push_back({A_DX, 32'h0000_000C});
    exp_wr_q.push_back({A_DY, 32'h0000_0020});
    exp_wr_q.push_back({A_DZ, 32'h0000_1770});
    exp_wr_q.push_back({A_XADR, 32'h1000_0000});
    exp_wr_q.push_back({A_WCFG, 32'h0004_1804});
    exp_wr_q.push_back({A_XADR, 32'h1000_0000});
    exp_wr_q.push_back({A_RCFG, 32'h0004_1804});
  endtask

  task automatic setup0(input int la, input int wa, input int ra,
                        input logic [31:0] fs, input int wc);
    link_at = la; wr_at = wa; rd_at = ra; final_sts = fs; wait_cycles = wc;
    n_link = 0; n_wrp = 0; n_rdp = 0; n_final = 0; rd_phase = 1'b0;
  endtask

  task automatic run0(input int la, input int wa, input int ra,
                      input logic [31:0] fs, input int wc, input bit dbl);
    logic [3:0] v;
    setup0(la, wa, ra, fs, wc);
    push_writes();
    v = exp_verdict(fs[3:0]);
    exp_v_q.push_back({v, fs});
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check("start_latency", {wr0, addr0, wdat0}, {1'b1, A_DX, 32'h0000_000C});
    if (dbl) begin
      repeat (40) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      check("busy_during_run", {63'd0, busy0}, 64'd1);
    end
    for (int i = 0; i < 30000 && !done0; i++) @(negedge clk);
    check("done0_reached", {63'd0, done0}, 64'd1);
    repeat (2) @(negedge clk);
    check("link_polls", 64'(n_link), 64'(la));
    check("wr_polls", 64'(n_wrp), 64'(wa));
    check("final_reads", 64'(n_final), 64'd1);
    check("writes_left", 64'(exp_wr_q.size()), 64'd0);
    exp_wr_q.delete();
  endtask

  initial begin
    setup0(1, 1, 1, 32'h0, 0);
    repeat (3) @(negedge clk);
    check("reset_outs", {busy0, done0, pass0, code0, wr0, rd0, last0},
          {7'd0, 32'd0});
    check("reset_addr", {addr0, wdat0}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run0(3, 5, 2, 32'h3F, 0, 1'b0);
    run0(3, 5, 2, 32'h3E, 0, 1'b0);
    run0(3, 5, 2, 32'h3B, 0, 1'b0);
    run0(3, 5, 2, 32'h37, 0, 1'b0);
    run0(3, 5, 2, 32'h3F, 7, 1'b0);
    for (int k = 0; k < 6; k++)
      run0($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6),
           $urandom, $urandom_range(0, 4), 1'b0);

    // link never up on the small-limit instance
    exp_v1_q.push_back({1'b0, 3'd1, 32'd0});
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 5000 && !done1; i++) @(negedge clk);
    check("done1_reached", {63'd0, done1}, 64'd1);
    repeat (2) @(negedge clk);
    check("limit_link_reads", 64'(n_link1), 64'(LIM1));
    check("limit_spacing_ok", {63'd0, (min_sp1 >= GAP + 1)}, 64'd1);
    check("limit_no_wrcfg", 64'(n_wrcfg1), 64'd0);
    check("limit_dly_writes", 64'(n_wr1), 64'd3);
    check("limit_bad_reads", 64'(n_bad1), 64'd0);

    // reset while polling write completion
    setup0(2, 50, 2, 32'h3F, 3);
    push_writes();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #2;
      if (n_wrp >= 2 && rd0) break;
    end
    check("pre_reset_read", {63'd0, rd0}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_strobes", {62'd0, rd0, wr0}, 64'd0);
    check("rst_status", {busy0, done0, pass0, code0, last0}, {6'd0, 32'd0});
    check("rst_addr", {addr0, wdat0}, 64'd0);
    repeat (2) @(negedge clk);
    exp_wr_q.delete();
    rst_n = 1'b1;
    stray = 1'b1;
    repeat (6) @(negedge clk);
    check("stray_ignored", {busy0, done0, rd0, wr0, last0}, {4'd0, 32'd0});

    run0(3, 5, 2, 32'h3F, 0, 1'b0);
    run0(2, 3, 2, 32'h3F, 1, 1'b1);

    check("verdicts_left", 64'(exp_v_q.size() + exp_v1_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
